// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions: parity mode encodings, the parity
// checker state type and the legal data-width range.
package uart_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int unsigned DATA_WIDTH_MIN = 5;
  localparam int unsigned DATA_WIDTH_MAX = 9;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } par_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coincident with an increment leaves a
// count of one so the new event is not lost.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= i_inc ? WIDTH'(1) : '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_parity_checker.sv
// UART receive parity checker: assembles the data word LSB-first, accumulates
// parity serially and checks the parity bit in one of four latched modes.
module rx_parity_checker
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PAR_EN,
  input  logic [1:0]               PAR_MODE,
  input  logic                     frame_start,
  input  logic                     bit_valid,
  input  logic                     sampled_bit,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    P_DATA,
  output logic                     chk_done,
  output logic                     par_err,
  output logic                     par_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  par_state_t            r_state;
  logic                  r_acc;
  logic [CntW-1:0]       r_bit_cnt;
  logic                  r_par_en;
  logic [1:0]            r_par_mode;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_chk_done;
  logic                  r_par_err;
  logic                  r_sticky;
  logic                  w_expected;

  always_comb begin
    w_expected = r_acc;
    unique case (r_par_mode)
      PAR_EVEN:  w_expected = r_acc;
      PAR_ODD:   w_expected = ~r_acc;
      PAR_MARK:  w_expected = 1'b1;
      PAR_SPACE: w_expected = 1'b0;
      default:   w_expected = r_acc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StIdle;
      r_acc      <= 1'b0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_mode <= PAR_EVEN;
      r_data     <= '0;
      r_chk_done <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      r_chk_done <= 1'b0;
      r_par_err  <= 1'b0;
      // A new start bit restarts the frame; any same-cycle data bit is dropped.
      if (frame_start) begin
        r_acc      <= 1'b0;
        r_bit_cnt  <= '0;
        r_par_en   <= PAR_EN;
        r_par_mode <= PAR_MODE;
        r_state    <= StData;
      end else begin
        case (r_state)
          StData: begin
            if (bit_valid) begin
              r_data[r_bit_cnt] <= sampled_bit;
              r_acc             <= r_acc ^ sampled_bit;
              r_bit_cnt         <= r_bit_cnt + CntW'(1);
              if (r_bit_cnt == CntW'(DATA_WIDTH - 1)) begin
                if (r_par_en) begin
                  r_state <= StParity;
                end else begin
                  r_state    <= StIdle;
                  r_chk_done <= 1'b1;
                end
              end
            end
          end
          StParity: begin
            if (bit_valid) begin
              r_chk_done <= 1'b1;
              r_par_err  <= (sampled_bit != w_expected);
              r_state    <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sticky <= 1'b0;
    end else if (err_clr) begin
      r_sticky <= r_par_err;
    end else if (r_par_err) begin
      r_sticky <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_inc  (r_par_err),
    .i_clr  (err_clr),
    .o_count(err_count)
  );

  assign P_DATA         = r_data;
  assign chk_done       = r_chk_done;
  assign par_err        = r_par_err;
  assign par_err_sticky = r_sticky;

endmodule
